// File: rtl/hazard_scoreboard.sv
// ID-side hazard scoreboard: registered shadow of in-flight destinations, stall and forward selects.
// Optional forwarding build: define HAZARD_FORWARDING_EN.
module hazard_scoreboard #(
    parameter int DEPTH = 2,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             is_im,
    input  logic             is_br,
    input  logic             br_type,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_is_load,
    input  logic             mem_ready,
    input  logic             flush,
    input  logic             stat_clr,
    output logic             hazard_detected,
    output logic [2:0]       fwd_sel1,
    output logic [2:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_count
);

    logic [DEPTH:1]   r_v;
    logic [DEPTH:1]   r_wb;
    logic [DEPTH:1]   r_ld;
    logic [REG_W-1:0] r_dest [1:DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic           w_use1;
    logic           w_use2;
    logic [DEPTH:1] w_m1;
    logic [DEPTH:1] w_m2;
    logic           w_haz;

    always_comb begin
        w_use1 = |src1;
        w_use2 = (|src2) && (!is_im || (is_br && !br_type));
        w_m1   = '0;
        w_m2   = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_m1[k] = w_use1 && r_v[k] && r_wb[k] && (r_dest[k] == src1);
            w_m2[k] = w_use2 && r_v[k] && r_wb[k] && (r_dest[k] == src2);
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [2:0] w_near1;
    logic [2:0] w_near2;
    logic       w_nld1;
    logic       w_nld2;
    logic       w_h1;
    logic       w_h2;

    // Walk from the far end so the nearest (lowest k) match wins.
    always_comb begin
        w_near1 = '0;
        w_near2 = '0;
        w_nld1  = 1'b0;
        w_nld2  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_m1[k]) begin
                w_near1 = 3'(k);
                w_nld1  = r_ld[k];
            end
            if (w_m2[k]) begin
                w_near2 = 3'(k);
                w_nld2  = r_ld[k];
            end
        end
    end

    // Branches resolve in ID, so they cannot take an EXE result in time.
    assign w_h1 = is_br ? ((w_near1 == 3'd1) || ((w_near1 == 3'd2) && w_nld1))
                        : ((w_near1 == 3'd1) && w_nld1);
    assign w_h2 = is_br ? ((w_near2 == 3'd1) || ((w_near2 == 3'd2) && w_nld2))
                        : ((w_near2 == 3'd1) && w_nld2);

    assign w_haz    = id_valid && (w_h1 || w_h2);
    assign fwd_sel1 = w_haz ? 3'd0 : w_near1;
    assign fwd_sel2 = w_haz ? 3'd0 : w_near2;
`else
    logic w_unused_ld;

    assign w_unused_ld = ^r_ld;
    assign w_haz       = id_valid && ((|w_m1) || (|w_m2));
    assign fwd_sel1    = '0;
    assign fwd_sel2    = '0;
`endif

    assign hazard_detected = w_haz;
    assign stall_count     = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_wb <= '0;
            r_ld <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_dest[k] <= '0;
            end
        end else if (flush) begin
            r_v <= '0;
        end else if (mem_ready) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_v[k]    <= r_v[k-1];
                r_wb[k]   <= r_wb[k-1];
                r_ld[k]   <= r_ld[k-1];
                r_dest[k] <= r_dest[k-1];
            end
            r_v[1]    <= id_valid && !w_haz;
            r_wb[1]   <= id_wb_en;
            r_ld[1]   <= id_is_load;
            r_dest[1] <= id_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (stat_clr) begin
            r_cnt <= '0;
        end else if (w_haz && mem_ready && !flush && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table plus freeze/flush/saturation/reset sequences.
module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       im;
        logic       br;
        logic       bt;
        logic [4:0] d;
        logic       wb;
        logic       ld;
        logic       h_nf;
        logic       h_fw;
        logic [2:0] f1;
        logic [2:0] f2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        is_im;
    logic        is_br;
    logic        br_type;
    logic [4:0]  id_dest;
    logic        id_wb_en;
    logic        id_is_load;
    logic        mem_ready;
    logic        flush;
    logic        stat_clr;
    logic        hazard_detected;
    logic [2:0]  fwd_sel1;
    logic [2:0]  fwd_sel2;
    logic [15:0] stall_count;
    logic        sat_haz;
    logic [2:0]  sat_f1;
    logic [2:0]  sat_f2;
    logic [1:0]  sat_count;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.DEPTH(2), .REG_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .src1(src1), .src2(src2), .is_im(is_im), .is_br(is_br),
        .br_type(br_type), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_is_load(id_is_load), .mem_ready(mem_ready), .flush(flush),
        .stat_clr(stat_clr), .hazard_detected(hazard_detected),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_count(stall_count)
    );

    hazard_scoreboard #(.DEPTH(2), .REG_W(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .src1(src1), .src2(src2), .is_im(is_im), .is_br(is_br),
        .br_type(br_type), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_is_load(id_is_load), .mem_ready(mem_ready), .flush(flush),
        .stat_clr(stat_clr), .hazard_detected(sat_haz),
        .fwd_sel1(sat_f1), .fwd_sel2(sat_f2), .stall_count(sat_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [4:0] s1,
                                input logic [4:0] s2, input logic im,
                                input logic br, input logic bt,
                                input logic [4:0] d, input logic wb,
                                input logic ld, input logic hnf,
                                input logic hfw, input logic [2:0] f1,
                                input logic [2:0] f2);
        vec_t r;
        r.v = v; r.s1 = s1; r.s2 = s2; r.im = im; r.br = br; r.bt = bt;
        r.d = d; r.wb = wb; r.ld = ld; r.h_nf = hnf; r.h_fw = hfw;
        r.f1 = f1; r.f2 = f2;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        id_valid   = t.v;
        src1       = t.s1;
        src2       = t.s2;
        is_im      = t.im;
        is_br      = t.br;
        br_type    = t.bt;
        id_dest    = t.d;
        id_wb_en   = t.wb;
        id_is_load = t.ld;
    endtask

    task automatic set(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic wb, input logic ld);
        drive(mk(v, s1, s2, 1'b0, 1'b0, 1'b0, d, wb, ld, 1'b0, 1'b0, 3'd0, 3'd0));
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [24];

    initial begin
        tbl[0]  = mk(1, 0, 0, 0,0,0,  3,1,0, 0,0, 0,0);
        tbl[1]  = mk(1, 3, 0, 0,0,0,  0,0,0, 1,0, 1,0);
        tbl[2]  = mk(1, 3, 0, 0,0,0,  0,0,0, 1,0, 2,0);
        tbl[3]  = mk(1, 3, 0, 0,0,0,  0,0,0, 0,0, 0,0);
        tbl[4]  = mk(1, 0, 0, 0,0,0,  5,1,1, 0,0, 0,0);
        tbl[5]  = mk(1, 0, 5, 0,0,0,  0,0,0, 1,1, 0,0);
        tbl[6]  = mk(1, 0, 5, 0,0,0,  0,0,0, 1,0, 0,2);
        tbl[7]  = mk(1, 0, 0, 0,0,0,  5,1,1, 0,0, 0,0);
        tbl[8]  = mk(1, 0, 5, 1,0,0,  0,0,0, 0,0, 0,0);
        tbl[9]  = mk(1, 0, 0, 0,0,0,  7,1,0, 0,0, 0,0);
        tbl[10] = mk(1, 0, 7, 1,1,0,  0,0,0, 1,1, 0,0);
        tbl[11] = mk(1, 0, 7, 1,1,0,  0,0,0, 1,0, 0,2);
        tbl[12] = mk(1, 0, 0, 0,0,0,  7,1,0, 0,0, 0,0);
        tbl[13] = mk(1, 0, 7, 1,1,1,  0,0,0, 0,0, 0,0);
        tbl[14] = mk(1, 0, 0, 0,0,0,  0,1,0, 0,0, 0,0);
        tbl[15] = mk(1, 0, 0, 0,0,0,  0,0,0, 0,0, 0,0);
        tbl[16] = mk(1, 0, 0, 0,0,0,  9,1,0, 0,0, 0,0);
        tbl[17] = mk(0, 9, 0, 0,0,0,  0,0,0, 0,0, 1,0);
        tbl[18] = mk(1, 9, 0, 0,0,0,  0,0,0, 1,0, 2,0);
        tbl[19] = mk(1, 0, 0, 0,0,0, 10,1,0, 0,0, 0,0);
        tbl[20] = mk(1, 0, 0, 0,0,0, 11,1,0, 0,0, 0,0);
        tbl[21] = mk(1,10,11, 0,0,0,  0,0,0, 1,0, 2,1);
        tbl[22] = mk(0, 0, 0, 0,0,0,  0,0,0, 0,0, 0,0);
        tbl[23] = mk(0, 0, 0, 0,0,0,  0,0,0, 0,0, 0,0);

        rst_n     = 1'b0;
        mem_ready = 1'b1;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        set(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        chk("rst_haz", hazard_detected, 0);
        chk("rst_f1", fwd_sel1, 0);
        chk("rst_f2", fwd_sel2, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_sat", sat_count, 0);
        rst_n = 1'b1;
        edge1();

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d_haz", i), hazard_detected, FWD ? tbl[i].h_fw : tbl[i].h_nf);
            chk($sformatf("v%0d_f1", i), fwd_sel1, FWD ? tbl[i].f1 : 3'd0);
            chk($sformatf("v%0d_f2", i), fwd_sel2, FWD ? tbl[i].f2 : 3'd0);
            edge1();
        end

        @(negedge clk);
        chk("tbl_cnt", stall_count, FWD ? 2 : 8);
        chk("tbl_sat", sat_count, FWD ? 2 : 3);
        stat_clr = 1'b1;
        edge1();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_cnt", stall_count, 0);
        chk("clr_sat", sat_count, 0);

        // freeze with a load of r4 in entry 1
        set(1, 0, 0, 4, 1, 1);
        edge1();
        set(1, 4, 0, 0, 0, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("frz%0d_haz", i), hazard_detected, 1);
            chk($sformatf("frz%0d_cnt", i), stall_count, 0);
            edge1();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rel_haz", hazard_detected, 1);
        edge1();
        @(negedge clk);
        chk("rel_cnt1", stall_count, 1);
        chk("rel_haz2", hazard_detected, FWD ? 0 : 1);
        chk("rel_f1", fwd_sel1, FWD ? 2 : 0);
        edge1();
        @(negedge clk);
        chk("rel_cnt2", stall_count, FWD ? 1 : 2);
        set(0, 0, 0, 0, 0, 0);
        edge1();
        edge1();

        // flush with a hazard pending
        set(1, 0, 0, 6, 1, 0);
        edge1();
        set(1, 0, 0, 8, 1, 1);
        edge1();
        set(1, 8, 0, 0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_haz_pre", hazard_detected, 1);
        edge1();
        flush = 1'b0;
        set(1, 8, 6, 0, 0, 0);
        @(negedge clk);
        chk("fl_haz", hazard_detected, 0);
        chk("fl_f1", fwd_sel1, 0);
        chk("fl_f2", fwd_sel2, 0);
        chk("fl_cnt", stall_count, FWD ? 1 : 2);
        edge1();

        // flush while frozen
        set(1, 0, 0, 6, 1, 0);
        edge1();
        set(1, 0, 0, 8, 1, 1);
        edge1();
        set(1, 8, 0, 0, 0, 0);
        flush     = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("flf_haz_pre", hazard_detected, 1);
        edge1();
        flush     = 1'b0;
        mem_ready = 1'b1;
        set(1, 8, 6, 0, 0, 0);
        @(negedge clk);
        chk("flf_haz", hazard_detected, 0);
        chk("flf_f1", fwd_sel1, 0);
        chk("flf_f2", fwd_sel2, 0);
        chk("flf_cnt", stall_count, FWD ? 1 : 2);
        set(0, 0, 0, 0, 0, 0);
        edge1();
        edge1();

        // saturation on the CNT_W=2 instance
        stat_clr = 1'b1;
        edge1();
        stat_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set(1, 0, 0, 12, 1, 1);
            edge1();
            set(1, 12, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("sat%0d_haz", i), hazard_detected, 1);
            edge1();
            set(0, 0, 0, 0, 0, 0);
            edge1();
            edge1();
            @(negedge clk);
            chk($sformatf("sat%0d_cnt", i), stall_count, i + 1);
            chk($sformatf("sat%0d_sat", i), sat_count, (i + 1 > 3) ? 3 : i + 1);
        end
        set(1, 0, 0, 12, 1, 1);
        edge1();
        set(1, 12, 0, 0, 0, 0);
        stat_clr = 1'b1;
        @(negedge clk);
        chk("sclr_haz", sat_haz, 1);
        edge1();
        stat_clr = 1'b0;
        set(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sclr_cnt", stall_count, 0);
        chk("sclr_sat", sat_count, 0);
        edge1();
        edge1();

        // asynchronous reset mid-cycle
        set(1, 0, 0, 13, 1, 0);
        edge1();
        set(1, 13, 0, 0, 0, 0);
        @(negedge clk);
        chk("ar_haz_pre", hazard_detected, FWD ? 0 : 1);
        chk("ar_f1_pre", fwd_sel1, FWD ? 1 : 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_haz", hazard_detected, 0);
        chk("ar_f1", fwd_sel1, 0);
        chk("ar_cnt", stall_count, 0);
        edge1();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_haz_post", hazard_detected, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
